// File: rtl/icb_acc_pkg.sv
// Shared constants and types for the accelerator ICB responder.
package icb_acc_pkg;

  localparam int unsigned ICB_DW = 32;
  localparam int unsigned OFF_W  = 13;

  localparam logic [OFF_W-1:0] CTRL_OFF = 13'h000;
  localparam logic [OFF_W-1:0] MODE_OFF = 13'h004;
  localparam logic [OFF_W-1:0] DATA_OFF = 13'h008;

  localparam logic [2:0] MODE_BUF      = 3'd0;
  localparam logic [2:0] MODE_TANH_POS = 3'd2;
  localparam logic [2:0] MODE_TANH_NEG = 3'd4;

  typedef struct packed {
    logic [ICB_DW-1:0] rdata;
    logic              err;
  } icb_rsp_t;

  typedef enum logic {
    ST_IDLE,
    ST_RSP
  } rsp_state_e;

endpackage

// File: rtl/icb_acc_decode.sv
// Address decoder: splits a bus address into CTRL, MODE and data-window hits.
module icb_acc_decode
  import icb_acc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1004_2000,
  parameter int unsigned DEPTH     = 4096,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic [31:0]   addr,
  output logic          hit_ctrl,
  output logic          hit_mode,
  output logic          hit_data,
  output logic [AW-1:0] entry,
  output logic          err
);

  logic             base_hit;
  logic [OFF_W-1:0] off;
  logic [OFF_W-1:0] rel;

  always_comb begin
    base_hit = (addr[31:13] == BASE_ADDR[31:13]);
    off      = addr[12:0];
    rel      = off - DATA_OFF;
    hit_ctrl = base_hit && (off == CTRL_OFF);
    hit_mode = base_hit && (off == MODE_OFF);
    // Data window is one entry per address step, DEPTH entries long
    hit_data = base_hit && (off >= DATA_OFF) && (32'(rel) < DEPTH);
    entry    = rel[AW-1:0];
    err      = !(hit_ctrl || hit_mode || hit_data);
  end

endmodule

// File: rtl/icb_acc_slave_if.sv
// ICB responder for the accelerator: register file, data-window bridge and
// start/busy/done handshake toward the compute core.
module icb_acc_slave_if
  import icb_acc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1004_2000,
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned DW        = ICB_DW,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          icb_cmd_valid,
  output logic          icb_cmd_ready,
  input  logic          icb_cmd_read,
  input  logic [31:0]   icb_cmd_addr,
  input  logic [DW-1:0] icb_cmd_wdata,
  input  logic [3:0]    icb_cmd_wmask,
  output logic          icb_rsp_valid,
  input  logic          icb_rsp_ready,
  output logic [DW-1:0] icb_rsp_rdata,
  output logic          icb_rsp_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [2:0]    mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic [DW-1:0] mem_rdata,
  output logic          acc_start,
  input  logic          acc_done,
  output logic          acc_busy
);

  rsp_state_e    state_q, state_d;
  logic          rsp_hs;
  logic          accept;
  logic          hit_ctrl, hit_mode, hit_data, dec_err;
  logic [AW-1:0] entry;

  logic [2:0]    mode_q;
  logic          ctrl_go_q;
  logic          done_sticky_q;
  logic          busy_q;
  logic          start_q;
  icb_rsp_t      rsp_q;
  logic          rsp_first_q;
  logic          rsp_mem_rd_q;

  logic          reg_wr, mode_wr, ctrl_wr, start_go;
  logic [DW-1:0] rd_value;

  icb_acc_decode #(
    .BASE_ADDR (BASE_ADDR),
    .DEPTH     (DEPTH)
  ) u_decode (
    .addr     (icb_cmd_addr),
    .hit_ctrl (hit_ctrl),
    .hit_mode (hit_mode),
    .hit_data (hit_data),
    .entry    (entry),
    .err      (dec_err)
  );

  // Response-slot state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Handshake, next state and the accept-cycle memory strobe
  always_comb begin
    state_d       = state_q;
    rsp_hs        = (state_q == ST_RSP) && icb_rsp_ready;
    icb_cmd_ready = !rst && ((state_q == ST_IDLE) || rsp_hs);
    accept        = icb_cmd_valid && icb_cmd_ready;
    mem_en        = accept && hit_data;
    mem_we        = mem_en && !icb_cmd_read;
    mem_addr      = entry;
    mem_wdata     = icb_cmd_wdata;
    mem_wmask     = icb_cmd_wmask;
    if (accept)      state_d = ST_RSP;
    else if (rsp_hs) state_d = ST_IDLE;
  end

  // Register write qualification and read-value selection at accept time
  always_comb begin
    reg_wr   = accept && !icb_cmd_read;
    mode_wr  = reg_wr && hit_mode && icb_cmd_wmask[0];
    ctrl_wr  = reg_wr && hit_ctrl && icb_cmd_wmask[0];
    // A completion arriving in the same cycle frees the core for a new start
    start_go = ctrl_wr && icb_cmd_wdata[0] && !ctrl_go_q && (!busy_q || acc_done);
    rd_value = '0;
    if (icb_cmd_read) begin
      if (hit_ctrl)      rd_value = DW'({done_sticky_q, busy_q});
      else if (hit_mode) rd_value = DW'(mode_q);
    end
  end

  // Control/status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q        <= 3'd0;
      ctrl_go_q     <= 1'b0;
      done_sticky_q <= 1'b0;
      busy_q        <= 1'b0;
      start_q       <= 1'b0;
    end else begin
      start_q <= start_go;
      if (mode_wr) mode_q    <= icb_cmd_wdata[2:0];
      if (ctrl_wr) ctrl_go_q <= icb_cmd_wdata[0];
      if (start_go) begin
        busy_q        <= 1'b1;
        done_sticky_q <= 1'b0;
      end else if (acc_done) begin
        busy_q        <= 1'b0;
        done_sticky_q <= 1'b1;
      end
    end
  end

  // Response payload; data-window reads latch memory data on the first cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_q        <= '0;
      rsp_first_q  <= 1'b0;
      rsp_mem_rd_q <= 1'b0;
    end else if (accept) begin
      rsp_q        <= '{rdata: rd_value, err: dec_err};
      rsp_first_q  <= 1'b1;
      rsp_mem_rd_q <= hit_data && icb_cmd_read;
    end else begin
      rsp_first_q <= 1'b0;
      if (rsp_first_q && rsp_mem_rd_q) rsp_q.rdata <= mem_rdata;
    end
  end

  always_comb begin
    icb_rsp_valid = (state_q == ST_RSP);
    icb_rsp_err   = rsp_q.err;
    icb_rsp_rdata = (rsp_first_q && rsp_mem_rd_q) ? mem_rdata : rsp_q.rdata;
    mem_sel       = mode_q;
    acc_start     = start_q;
    acc_busy      = busy_q;
  end

endmodule

// File: tb/tb_icb_acc_slave_if.sv
// Self-checking bench for icb_acc_slave_if with a memory model and an
// address-map level reference model.
module tb_icb_acc_slave_if;

  localparam logic [31:0] BASE = 32'h1004_2000;

  logic        clk, rst;
  logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
  logic [31:0] icb_rsp_rdata;
  logic        mem_en, mem_we;
  logic [2:0]  mem_sel;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        acc_start, acc_done, acc_busy;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int mem_en_cnt = 0;

  bit [31:0] mem_arr [8][4096];
  bit [31:0] ref_mem [8][4096];
  bit [2:0]  m_mode;
  bit        m_go, m_busy, m_done;

  icb_acc_slave_if dut (
    .clk(clk), .rst(rst),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .acc_start(acc_start), .acc_done(acc_done), .acc_busy(acc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory: 1-cycle read latency, garbage on idle cycles
  always @(posedge clk) begin
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem_arr[mem_sel][mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
    if (mem_en && !mem_we) mem_rdata <= mem_arr[mem_sel][mem_addr];
    else                   mem_rdata <= $urandom;
  end

  always @(posedge clk) begin
    if (acc_start) start_cnt <= start_cnt + 1;
    if (mem_en)    mem_en_cnt <= mem_en_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: applies one access against the address map
  task automatic model_access(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wmask, output logic [31:0] e_rdata,
                              output bit e_err, output bit e_mem, output bit e_start,
                              output logic [11:0] e_entry, output logic [2:0] e_sel);
    int off;
    e_rdata = 0; e_err = 0; e_mem = 0; e_start = 0; e_entry = 0; e_sel = m_mode;
    off = int'(addr % 32'd8192);
    if ((addr / 32'd8192) != (BASE / 32'd8192)) e_err = 1;
    else if (off == 0) begin
      if (rd) e_rdata = 32'(m_done * 2 + m_busy);
      else if (wmask[0]) begin
        if (wdata[0] && !m_go && !m_busy) begin
          e_start = 1; m_busy = 1; m_done = 0;
        end
        m_go = wdata[0];
      end
    end else if (off == 4) begin
      if (rd) e_rdata = 32'(m_mode);
      else if (wmask[0]) m_mode = wdata[2:0];
    end else if (off >= 8 && off < 8 + 4096) begin
      e_mem = 1;
      e_entry = 12'(off - 8);
      if (rd) e_rdata = ref_mem[m_mode][off - 8];
      else
        for (int b = 0; b < 4; b++)
          if (wmask[b]) ref_mem[m_mode][off - 8][b*8 +: 8] = wdata[b*8 +: 8];
    end else e_err = 1;
  endtask

  // Drives one command and collects its response; bad counts protocol violations
  task automatic icb_xact(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask, input int stall,
                          output logic [31:0] rdata, output logic err,
                          output logic o_en, output logic o_we, output logic [2:0] o_sel,
                          output logic [11:0] o_addr, output int bad);
    int n;
    bad = 0;
    icb_cmd_valid = 1'b1; icb_cmd_read = rd; icb_cmd_addr = addr;
    icb_cmd_wdata = wdata; icb_cmd_wmask = wmask; icb_rsp_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (icb_cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) bad++;
    o_en = mem_en; o_we = mem_we; o_sel = mem_sel; o_addr = mem_addr;
    @(posedge clk); #1;
    icb_cmd_valid = 1'b0;
    @(negedge clk);
    if (icb_rsp_valid !== 1'b1) bad++;
    rdata = icb_rsp_rdata; err = icb_rsp_err;
    for (int i = 0; i < stall; i++) begin
      if (icb_rsp_valid !== 1'b1 || icb_cmd_ready !== 1'b0 ||
          icb_rsp_rdata !== rdata || icb_rsp_err !== err) bad++;
      @(negedge clk);
    end
    if (icb_rsp_rdata !== rdata) bad++;
    icb_rsp_ready = 1'b1;
    @(posedge clk); #1;
    icb_rsp_ready = 1'b0;
  endtask

  // Access that updates the model and discards mem-side observations
  task automatic quick(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic [31:0] e_rdata);
    logic err, en, we; logic [2:0] sel, e_sel; logic [11:0] ad, e_entry;
    bit e_err, e_mem, e_start; int bad;
    model_access(rd, addr, wdata, 4'hF, e_rdata, e_err, e_mem, e_start, e_entry, e_sel);
    icb_xact(rd, addr, wdata, 4'hF, 0, rdata, err, en, we, sel, ad, bad);
  endtask

  task automatic pulse_done;
    acc_done = 1'b1;
    @(posedge clk); #1;
    acc_done = 1'b0;
    m_busy = 0; m_done = 1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (icb_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", icb_rsp_valid); end
    checks++; if (icb_rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", icb_rsp_err); end
    checks++; if (icb_rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", icb_rsp_rdata); end
    checks++; if (acc_start !== 1'b0 || acc_busy !== 1'b0) begin failures++; $display("FAIL reset_acc got=%b%b exp=00", acc_start, acc_busy); end
    checks++; if (mem_sel !== 3'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", mem_sel); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (icb_cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%b exp=1", icb_cmd_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_data_window;
    logic [31:0] rdata, e_rdata; logic err, en, we; logic [2:0] sel, e_sel;
    logic [11:0] ad, e_entry; bit e_err, e_mem, e_start; int bad;
    model_access(0, BASE + 32'd4, 32'd2, 4'h1, e_rdata, e_err, e_mem, e_start, e_entry, e_sel);
    icb_xact(0, BASE + 32'd4, 32'd2, 4'h1, 0, rdata, err, en, we, sel, ad, bad);
    checks++; if (err !== 1'b0 || bad != 0) begin failures++; $display("FAIL mode_wr err=%b bad=%0d exp err=0 bad=0", err, bad); end
    model_access(0, BASE + 32'd13, 32'h3C00, 4'hF, e_rdata, e_err, e_mem, e_start, e_entry, e_sel);
    icb_xact(0, BASE + 32'd13, 32'h3C00, 4'hF, 0, rdata, err, en, we, sel, ad, bad);
    checks++; if (en !== 1'b1 || we !== 1'b1) begin failures++; $display("FAIL dw_wr_strobe en=%b we=%b exp=11", en, we); end
    checks++; if (sel !== 3'd2 || ad !== 12'd5) begin failures++; $display("FAIL dw_wr_addr sel=%0d addr=%0d exp sel=2 addr=5", sel, ad); end
    checks++; if (err !== 1'b0 || bad != 0) begin failures++; $display("FAIL dw_wr_rsp err=%b bad=%0d exp 0/0", err, bad); end
    model_access(1, BASE + 32'd13, 0, 4'h0, e_rdata, e_err, e_mem, e_start, e_entry, e_sel);
    icb_xact(1, BASE + 32'd13, 0, 4'h0, 3, rdata, err, en, we, sel, ad, bad);
    checks++; if (rdata !== 32'h0000_3C00) begin failures++; $display("FAIL dw_rd_data got=%h exp=00003c00", rdata); end
    checks++; if (bad != 0 || we !== 1'b0) begin failures++; $display("FAIL dw_rd_stall bad=%0d we=%b exp 0/0", bad, we); end
  endtask

  task automatic test_ctrl_start;
    logic [31:0] rdata, e_rdata; int s0;
    s0 = start_cnt;
    quick(0, BASE, 32'd1, rdata, e_rdata);
    quick(0, BASE, 32'd0, rdata, e_rdata);
    quick(1, BASE, 0, rdata, e_rdata);
    checks++; if (rdata !== 32'h1) begin failures++; $display("FAIL ctrl_rd_busy got=%h exp=1", rdata); end
    repeat (50) @(posedge clk);
    #1;
    pulse_done;
    quick(1, BASE, 0, rdata, e_rdata);
    checks++; if (rdata !== 32'h2) begin failures++; $display("FAIL ctrl_rd_done got=%h exp=2", rdata); end
    checks++; if (start_cnt - s0 != 1) begin failures++; $display("FAIL start_once got=%0d exp=1", start_cnt - s0); end
    checks++; if (acc_busy !== 1'b0) begin failures++; $display("FAIL busy_after_done got=%b exp=0", acc_busy); end
  endtask

  task automatic test_busy_restart;
    logic [31:0] rdata, e_rdata; int s0;
    s0 = start_cnt;
    quick(0, BASE, 32'd1, rdata, e_rdata);
    quick(0, BASE, 32'd0, rdata, e_rdata);
    quick(0, BASE, 32'd1, rdata, e_rdata);
    checks++; if (start_cnt - s0 != 1) begin failures++; $display("FAIL busy_no_pulse got=%0d exp=1", start_cnt - s0); end
    checks++; if (acc_busy !== 1'b1) begin failures++; $display("FAIL busy_held got=%b exp=1", acc_busy); end
    quick(0, BASE, 32'd0, rdata, e_rdata);
    // Fresh start coinciding with completion
    s0 = start_cnt;
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b0; icb_cmd_addr = BASE;
    icb_cmd_wdata = 32'd1; icb_cmd_wmask = 4'h1; icb_rsp_ready = 1'b1; acc_done = 1'b1;
    @(negedge clk);
    checks++; if (icb_cmd_ready !== 1'b1) begin failures++; $display("FAIL same_cycle_accept got=%b exp=1", icb_cmd_ready); end
    @(posedge clk); #1;
    icb_cmd_valid = 1'b0; acc_done = 1'b0;
    @(negedge clk);
    checks++; if (icb_rsp_valid !== 1'b1 || icb_rsp_err !== 1'b0) begin failures++; $display("FAIL same_cycle_rsp valid=%b err=%b exp 1/0", icb_rsp_valid, icb_rsp_err); end
    @(posedge clk); #1;
    icb_rsp_ready = 1'b0;
    m_go = 1; m_busy = 1; m_done = 0;
    checks++; if (acc_busy !== 1'b1 || start_cnt - s0 != 1) begin failures++; $display("FAIL same_cycle_busy busy=%b starts=%0d exp 1/1", acc_busy, start_cnt - s0); end
    quick(1, BASE, 0, rdata, e_rdata);
    checks++; if (rdata !== 32'h1) begin failures++; $display("FAIL same_cycle_ctrl got=%h exp=1", rdata); end
    pulse_done;
  endtask

  task automatic test_decode_err;
    logic [31:0] bad_addr [5];
    logic [31:0] rdata, e_rdata; logic err, en, we; logic [2:0] sel, e_sel;
    logic [11:0] ad, e_entry; bit e_err, e_mem, e_start; int bad, s0, m0;
    bad_addr = '{32'h1004_3008, 32'h2004_2000, BASE + 32'd1, BASE + 32'd7, BASE + 32'h1FFF};
    s0 = start_cnt; m0 = mem_en_cnt;
    for (int i = 0; i < 10; i++) begin
      model_access(i[0], bad_addr[i/2], 32'hFFFF_FFFF, 4'hF, e_rdata, e_err, e_mem, e_start, e_entry, e_sel);
      icb_xact(i[0], bad_addr[i/2], 32'hFFFF_FFFF, 4'hF, 0, rdata, err, en, we, sel, ad, bad);
      checks++;
      if (err !== 1'b1 || rdata !== 32'h0 || e_err != 1) begin
        failures++; $display("FAIL dec_err addr=%h err=%b rdata=%h exp err=1 rdata=0", bad_addr[i/2], err, rdata);
      end
    end
    checks++; if (mem_en_cnt != m0 || start_cnt != s0) begin failures++; $display("FAIL dec_err_side mem_en=%0d starts=%0d exp 0/0", mem_en_cnt - m0, start_cnt - s0); end
    quick(1, BASE + 32'd4, 0, rdata, e_rdata);
    checks++; if (rdata !== 32'd2) begin failures++; $display("FAIL dec_err_mode got=%h exp=2", rdata); end
    quick(1, BASE, 0, rdata, e_rdata);
    checks++; if (rdata !== 32'h2) begin failures++; $display("FAIL dec_err_ctrl got=%h exp=2", rdata); end
    // Last entry and masked-off write
    model_access(0, BASE + 32'd4103, 32'hA5A5_0001, 4'hF, e_rdata, e_err, e_mem, e_start, e_entry, e_sel);
    icb_xact(0, BASE + 32'd4103, 32'hA5A5_0001, 4'hF, 0, rdata, err, en, we, sel, ad, bad);
    checks++; if (err !== 1'b0 || en !== 1'b1 || ad !== 12'd4095) begin failures++; $display("FAIL last_entry err=%b en=%b addr=%0d exp 0/1/4095", err, en, ad); end
    model_access(0, BASE + 32'd13, 32'hDEAD_BEEF, 4'h0, e_rdata, e_err, e_mem, e_start, e_entry, e_sel);
    icb_xact(0, BASE + 32'd13, 32'hDEAD_BEEF, 4'h0, 1, rdata, err, en, we, sel, ad, bad);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL wmask0_err got=%b exp=0", err); end
    quick(1, BASE + 32'd13, 0, rdata, e_rdata);
    checks++; if (rdata !== 32'h0000_3C00) begin failures++; $display("FAIL wmask0_data got=%h exp=00003c00", rdata); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rdata, e_rdata; logic [31:0] addr, wdata;
    bit e_err, e_mem, e_start; logic [11:0] e_entry; logic [2:0] e_sel; int ok;
    ok = 0;
    icb_rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr = BASE + 32'd108 + 32'(i); wdata = $urandom;
      model_access(0, addr, wdata, 4'hF, e_rdata, e_err, e_mem, e_start, e_entry, e_sel);
      icb_cmd_valid = 1'b1; icb_cmd_read = 1'b0; icb_cmd_addr = addr;
      icb_cmd_wdata = wdata; icb_cmd_wmask = 4'hF;
      @(negedge clk);
      if (icb_cmd_ready === 1'b1 && mem_en === 1'b1 && (i == 0 || icb_rsp_valid === 1'b1)) ok++;
      @(posedge clk); #1;
    end
    icb_cmd_valid = 1'b0;
    checks++; if (ok != 8) begin failures++; $display("FAIL b2b_accept got=%0d exp=8", ok); end
    @(negedge clk);
    checks++; if (icb_rsp_valid !== 1'b1) begin failures++; $display("FAIL b2b_last_rsp got=%b exp=1", icb_rsp_valid); end
    @(posedge clk); #1;
    icb_rsp_ready = 1'b0;
    @(negedge clk);
    checks++; if (icb_rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", icb_rsp_valid); end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      quick(1, BASE + 32'd108 + 32'(i), 0, rdata, e_rdata);
      checks++; if (rdata !== e_rdata) begin failures++; $display("FAIL b2b_readback i=%0d got=%h exp=%h", i, rdata, e_rdata); end
    end
  endtask

  task automatic test_random;
    logic [31:0] addr, wdata, rdata, e_rdata; logic [3:0] wmask; bit rd;
    logic err, en, we; logic [2:0] sel, e_sel; logic [11:0] ad, e_entry;
    bit e_err, e_mem, e_start; int stall, s0, bad, k;
    for (int it = 0; it < 150; it++) begin
      rd = 1'($urandom_range(0, 1)); wdata = $urandom;
      wmask = 4'($urandom_range(0, 15)); stall = $urandom_range(0, 3);
      case ($urandom_range(0, 9))
        0: addr = BASE;
        1: addr = BASE + 32'd4;
        2: begin
          k = $urandom_range(0, 3);
          addr = BASE + (k == 0 ? 32'd1 : k == 1 ? 32'd6 : k == 2 ? 32'(4104 + $urandom_range(0, 4000)) : 32'h1FFF);
        end
        3: begin
          addr = $urandom;
          if ((addr >> 13) == (BASE >> 13)) addr = addr ^ 32'h8000_0000;
        end
        4: addr = BASE + 32'd8 + ($urandom_range(0, 1) == 1 ? 32'd4095 : 32'd0);
        default: addr = BASE + 32'd8 + 32'($urandom_range(0, 31));
      endcase
      s0 = start_cnt;
      model_access(rd, addr, wdata, wmask, e_rdata, e_err, e_mem, e_start, e_entry, e_sel);
      icb_xact(rd, addr, wdata, wmask, stall, rdata, err, en, we, sel, ad, bad);
      checks++; if (err !== e_err) begin failures++; $display("FAIL rnd_err it=%0d addr=%h got=%b exp=%b", it, addr, err, e_err); end
      checks++; if (rdata !== e_rdata) begin failures++; $display("FAIL rnd_rdata it=%0d addr=%h got=%h exp=%h", it, addr, rdata, e_rdata); end
      checks++; if (en !== e_mem) begin failures++; $display("FAIL rnd_mem_en it=%0d got=%b exp=%b", it, en, e_mem); end
      if (e_mem) begin
        checks++;
        if (we !== !rd || sel !== e_sel || ad !== e_entry) begin
          failures++; $display("FAIL rnd_mem_if it=%0d we=%b sel=%0d addr=%0d exp we=%b sel=%0d addr=%0d", it, we, sel, ad, !rd, e_sel, e_entry);
        end
      end
      checks++; if (start_cnt - s0 != int'(e_start)) begin failures++; $display("FAIL rnd_start it=%0d got=%0d exp=%0d", it, start_cnt - s0, e_start); end
      checks++; if (acc_busy !== m_busy) begin failures++; $display("FAIL rnd_busy it=%0d got=%b exp=%b", it, acc_busy, m_busy); end
      checks++; if (bad != 0) begin failures++; $display("FAIL rnd_protocol it=%0d violations=%0d exp=0", it, bad); end
      if ($urandom_range(0, 3) == 0) pulse_done;
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rdata, e_rdata;
    pulse_done;
    quick(0, BASE + 32'd4, 32'd3, rdata, e_rdata);
    quick(0, BASE, 32'd0, rdata, e_rdata);
    quick(0, BASE, 32'd1, rdata, e_rdata);
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = BASE + 32'd8; icb_rsp_ready = 1'b0;
    @(posedge clk); #1;
    icb_cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (icb_rsp_valid !== 1'b1 || acc_busy !== 1'b1) begin failures++; $display("FAIL mid_pending valid=%b busy=%b exp 1/1", icb_rsp_valid, acc_busy); end
    rst = 1'b1;
    icb_cmd_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (icb_rsp_valid !== 1'b0 || icb_rsp_err !== 1'b0 || icb_rsp_rdata !== 32'h0) begin
      failures++; $display("FAIL mid_rst_rsp valid=%b err=%b rdata=%h exp 0/0/0", icb_rsp_valid, icb_rsp_err, icb_rsp_rdata);
    end
    checks++; if (mem_en !== 1'b0 || acc_busy !== 1'b0 || acc_start !== 1'b0 || mem_sel !== 3'd0) begin
      failures++; $display("FAIL mid_rst_out mem_en=%b busy=%b start=%b sel=%0d exp 0/0/0/0", mem_en, acc_busy, acc_start, mem_sel);
    end
    icb_cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_mode = 0; m_go = 0; m_busy = 0; m_done = 0;
    @(negedge clk);
    checks++; if (icb_cmd_ready !== 1'b1 || icb_rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_post ready=%b valid=%b exp 1/0", icb_cmd_ready, icb_rsp_valid); end
    @(posedge clk); #1;
    quick(1, BASE, 0, rdata, e_rdata);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL mid_ctrl got=%h exp=0", rdata); end
    quick(1, BASE + 32'd4, 0, rdata, e_rdata);
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL mid_mode got=%h exp=0", rdata); end
  endtask

  initial begin
    rst = 1'b1; icb_cmd_valid = 1'b0; icb_cmd_read = 1'b0; icb_cmd_addr = '0;
    icb_cmd_wdata = '0; icb_cmd_wmask = '0; icb_rsp_ready = 1'b0; acc_done = 1'b0;
    test_reset();
    test_data_window();
    test_ctrl_start();
    test_busy_restart();
    test_decode_err();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icb_acc_slave_if.md
Name: icb_acc_slave_if

Overview:
- ICB responder front-end for the accelerator. It terminates the ICB bus driven by the E203 core, or by a bench initiator, at base 0x1004_2000.
- Decodes the control, mode and data-window regions.
- Converts accepted writes and reads into a single-port buffer/LUT memory interface and a start/busy/done control handshake toward the compute core.
- Sits between the ICB fabric and the accelerator datapath inside acc_top.

Parameters:
- BASE_ADDR, 32'h1004_2000, ICB base; region selected when addr[31:13] == BASE_ADDR[31:13].
- DEPTH, 4096, entries in the data window; memory address width is $clog2(DEPTH).
- DW, 32, data width of the ICB and memory ports.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- icb_cmd_valid  input  1  command valid
- icb_cmd_ready  output  1  command ready
- icb_cmd_read  input  1  1 = read, 0 = write
- icb_cmd_addr  input  32  command address
- icb_cmd_wdata  input  32  write data
- icb_cmd_wmask  input  4  byte enables for writes
- icb_rsp_valid  output  1  response valid
- icb_rsp_ready  input  1  response ready
- icb_rsp_rdata  output  32  read data
- icb_rsp_err  output  1  decode error
- mem_en  output  1  memory access strobe
- mem_we  output  1  memory write enable (qualified by mem_en)
- mem_sel  output  3  destination bank, equal to the MODE register
- mem_addr  output  12  entry index
- mem_wdata  output  32  memory write data
- mem_wmask  output  4  memory byte enables
- mem_rdata  input  32  memory read data, valid 1 cycle after mem_en with mem_we=0
- acc_start  output  1  one-cycle start pulse to the core
- acc_done  input  1  one-cycle completion pulse from the core
- acc_busy  output  1  core running

Behaviour:
- Address map, with off = addr[12:0]:
  - 0x000: CTRL
  - 0x004: MODE
  - 0x008 .. 0x008+DEPTH-1: data window, entry = off-8. Addressing is one entry per address increment, not byte-addressed.
  - Any other offset, or a base mismatch, is a decode error.
- Handshake:
  - One outstanding transaction.
  - icb_cmd_ready = !rsp_pending | (icb_rsp_valid & icb_rsp_ready).
  - Accept = icb_cmd_valid & icb_cmd_ready.
  - Every accepted command produces exactly one response, with icb_rsp_valid asserted the next cycle and held until icb_rsp_ready.
  - Responses are in order; there are no zero-latency responses.
- Data-window accept: mem_en=1 in the accept cycle (combinational from accept), with mem_we=!icb_cmd_read, mem_addr=entry, and mem_wdata/mem_wmask passed through.
- Read data:
  - Data-window read: icb_rsp_rdata = mem_rdata in the first rsp_valid cycle; the value is captured and held while the response stalls.
  - CTRL read: {30'b0, done_sticky, busy}.
  - MODE read: {29'b0, mode}.
  - Write responses return rdata 0.
- Writes apply only the byte lanes enabled in wmask; wmask=0 is a legal no-op with err=0.
- Register writes:
  - MODE write: mode <= wdata[2:0] under byte 0.
  - CTRL write with byte 0 enabled: ctrl_go <= wdata[0]. A 0->1 transition of ctrl_go while busy=0 pulses acc_start for 1 cycle, sets busy and clears done_sticky. A 0->1 while busy=1 updates ctrl_go only, with no pulse.
- Completion: acc_done clears busy and sets done_sticky. If acc_done and a qualifying start occur in the same cycle, busy ends at 1 and done_sticky at 0.
- Decode error: icb_rsp_err=1, rdata=0, no side effects, and no mem_en.
- Reset values: icb_rsp_valid=0, icb_rsp_err=0, icb_rsp_rdata=0, mem_en=0, acc_start=0, acc_busy=0, mode=0, ctrl_go=0, done_sticky=0, icb_cmd_ready=1 from the first post-reset cycle.
- Reset mid-transaction drops any pending response silently.

Decomposition:
- Package icb_acc_pkg holds:
  - offsets CTRL_OFF=13'h000, MODE_OFF=13'h004, DATA_OFF=13'h008;
  - mode encodings MODE_BUF=3'd0, MODE_TANH_POS=3'd2, MODE_TANH_NEG=3'd4;
  - typedef icb_rsp_t {rdata, err}.
- One sub-module, icb_acc_decode, is natural: combinational addr -> {hit_ctrl, hit_mode, hit_data, entry, err}.

Test Plan:
- Write MODE=2 at 0x1004_2004, then write 0x0000_3C00 at 0x1004_2008+5 -> mem_en=mem_we=1, mem_sel=2, mem_addr=5 in the accept cycle; rsp_valid next cycle, err=0.
- Read 0x1004_2008+5 with mem model returning 0x0000_3C00 and icb_rsp_ready held low 3 cycles -> rdata stays 0x0000_3C00 throughout; cmd_ready=0 until the response handshake.
- Write CTRL=1, then CTRL=0, with acc_done pulsed 50 cycles later -> acc_start pulses exactly once; CTRL read returns 0x1 during busy and 0x2 after done.
- Write CTRL=1 while busy -> no acc_start; then acc_done and a fresh 0->1 CTRL write in the same cycle -> busy=1, done_sticky=0.
- Access 0x1004_3008 and 0x2004_2000 -> rsp_err=1, mem_en never asserted, registers unchanged.
- Back-to-back writes with rsp_ready=1 every cycle -> one command accepted per cycle; assert rst during a pending response -> rsp_valid=0 the next cycle, all outputs at their reset values.
